// File: rtl/perf_snapshot.sv
// rtl/perf_snapshot.sv - perf counter snapshot with utilization divider, CSR read port and irq
module perf_snapshot #(
    parameter int COUNTER_WIDTH = 32,
    parameter int UTIL_W        = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     measurement_done,
    input  logic [COUNTER_WIDTH-1:0] total_cycles_count,
    input  logic [COUNTER_WIDTH-1:0] active_cycles_count,
    input  logic [COUNTER_WIDTH-1:0] idle_cycles_count,
    input  logic [COUNTER_WIDTH-1:0] cache_hit_count,
    input  logic [COUNTER_WIDTH-1:0] cache_miss_count,
    input  logic [COUNTER_WIDTH-1:0] decode_count,
    input  logic                     csr_rd_en,
    input  logic [2:0]               csr_rd_addr,
    output logic [31:0]              csr_rd_data,
    output logic                     csr_rd_valid,
    output logic [UTIL_W-1:0]        util_permille,
    output logic                     snap_valid,
    output logic                     busy,
    output logic                     irq,
    input  logic                     irq_clr
);

    localparam int CW    = COUNTER_WIDTH;
    localparam int NW    = CW + 10;
    localparam int CNT_W = $clog2(NW + 1);

    typedef enum logic [1:0] {IDLE, DIV, PUBLISH} state_t;

    state_t state, state_next;

    logic [CW-1:0]    sh_total, sh_active, sh_idle, sh_hits, sh_misses, sh_decode;
    logic [NW-1:0]    quo, quo_next, n_init;
    logic [CW-1:0]    rem, rem_next;
    logic [CW:0]      rem_shift;
    logic [CW+1:0]    diff;
    logic             ge;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      snap_seq;
    logic             overrun;
    logic             start;
    logic [31:0]      rd_mux;
    logic [UTIL_W-1:0] util_clamped;
    logic [1:0]       unused_bits;

    assign start  = measurement_done && (state == IDLE);
    assign n_init = NW'(active_cycles_count) * NW'(1000);

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_shift   = {rem, quo[NW-1]};
        diff        = {1'b0, rem_shift} - {2'b00, sh_total};
        ge          = ~diff[CW+1];
        rem_next    = ge ? diff[CW-1:0] : rem_shift[CW-1:0];
        quo_next    = {quo[NW-2:0], ge};
        unused_bits = {diff[CW], rem_shift[CW]};
    end

    assign util_clamped = (quo > NW'(1000)) ? UTIL_W'(1000) : quo[UTIL_W-1:0];

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (measurement_done) state_next = DIV;
            DIV:     if (sh_total == '0 || cnt == CNT_W'(NW - 1)) state_next = PUBLISH;
            PUBLISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rd_mux = '0;
        case (csr_rd_addr)
            3'd0: rd_mux = 32'(sh_total);
            3'd1: rd_mux = 32'(sh_active);
            3'd2: rd_mux = 32'(sh_idle);
            3'd3: rd_mux = 32'(sh_hits);
            3'd4: rd_mux = 32'(sh_misses);
            3'd5: rd_mux = 32'(sh_decode);
            3'd6: rd_mux = 32'(util_permille);
            3'd7: rd_mux = {overrun, 13'b0, snap_seq, busy, snap_valid};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_total      <= '0;
            sh_active     <= '0;
            sh_idle       <= '0;
            sh_hits       <= '0;
            sh_misses     <= '0;
            sh_decode     <= '0;
            quo           <= '0;
            rem           <= '0;
            cnt           <= '0;
            util_permille <= '0;
            snap_valid    <= 1'b0;
            busy          <= 1'b0;
            irq           <= 1'b0;
            overrun       <= 1'b0;
            snap_seq      <= '0;
            csr_rd_data   <= '0;
            csr_rd_valid  <= 1'b0;
        end else begin
            csr_rd_valid <= csr_rd_en;
            if (csr_rd_en) csr_rd_data <= rd_mux;

            if (start) begin
                sh_total   <= total_cycles_count;
                sh_active  <= active_cycles_count;
                sh_idle    <= idle_cycles_count;
                sh_hits    <= cache_hit_count;
                sh_misses  <= cache_miss_count;
                sh_decode  <= decode_count;
                quo        <= n_init;
                rem        <= '0;
                cnt        <= '0;
                busy       <= 1'b1;
                snap_valid <= 1'b0;
            end

            if (state == DIV) begin
                cnt <= cnt + 1'b1;
                if (sh_total == '0) begin
                    quo <= '0;
                end else begin
                    quo <= quo_next;
                    rem <= rem_next;
                end
            end

            if (state == PUBLISH) begin
                util_permille <= util_clamped;
                snap_valid    <= 1'b1;
                busy          <= 1'b0;
                snap_seq      <= snap_seq + 16'd1;
            end

            // A set on the same edge as a clear takes priority.
            if (state == PUBLISH) irq <= 1'b1;
            else if (irq_clr)     irq <= 1'b0;

            if (measurement_done && state != IDLE) overrun <= 1'b1;
            else if (irq_clr)                      overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_perf_snapshot.sv
// tb/tb_perf_snapshot.sv - self-checking bench for perf_snapshot
module tb_perf_snapshot;

    localparam int NW = 42;

    logic        clk = 1'b0;
    logic        rst;
    logic        measurement_done;
    logic [31:0] total_cycles_count, active_cycles_count, idle_cycles_count;
    logic [31:0] cache_hit_count, cache_miss_count, decode_count;
    logic        csr_rd_en;
    logic [2:0]  csr_rd_addr;
    logic [31:0] csr_rd_data;
    logic        csr_rd_valid;
    logic [9:0]  util_permille;
    logic        snap_valid, busy, irq, irq_clr;

    always #5 clk = ~clk;

    perf_snapshot #(.COUNTER_WIDTH(32), .UTIL_W(10)) dut (
        .clk                (clk),
        .rst                (rst),
        .measurement_done   (measurement_done),
        .total_cycles_count (total_cycles_count),
        .active_cycles_count(active_cycles_count),
        .idle_cycles_count  (idle_cycles_count),
        .cache_hit_count    (cache_hit_count),
        .cache_miss_count   (cache_miss_count),
        .decode_count       (decode_count),
        .csr_rd_en          (csr_rd_en),
        .csr_rd_addr        (csr_rd_addr),
        .csr_rd_data        (csr_rd_data),
        .csr_rd_valid       (csr_rd_valid),
        .util_permille      (util_permille),
        .snap_valid         (snap_valid),
        .busy               (busy),
        .irq                (irq),
        .irq_clr            (irq_clr)
    );

    typedef struct {
        logic [31:0] total, active, idle, hits, misses, decode;
        logic [9:0]  util;
    } vec_t;

    vec_t        vecs[7];
    vec_t        va, vb;
    logic [31:0] exp_q[$];
    int          total_n = 0;
    int          bad_n   = 0;
    logic [15:0] exp_seq = 16'd0;
    logic [31:0] prev_total = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_n++;
        if (act !== exp) begin
            bad_n++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        logic        pend;
        logic [31:0] e;
        pend = csr_rd_en;
        e    = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        if (pend && exp_q.size() > 0) e = exp_q.pop_front();
        if (pend || csr_rd_valid) begin
            chk("rd_valid", 32'(csr_rd_valid), 32'(pend));
            if (csr_rd_valid && pend) chk("rd_data", csr_rd_data, e);
        end
    endtask

    task automatic rd(input logic [2:0] addr, input logic [31:0] exp);
        csr_rd_en   = 1'b1;
        csr_rd_addr = addr;
        exp_q.push_back(exp);
        tick();
        csr_rd_en = 1'b0;
    endtask

    function automatic logic [31:0] st(input logic ov, input logic [15:0] s,
                                       input logic b, input logic v);
        return {ov, 13'b0, s, b, v};
    endfunction

    task automatic drive(input vec_t v);
        total_cycles_count  = v.total;
        active_cycles_count = v.active;
        idle_cycles_count   = v.idle;
        cache_hit_count     = v.hits;
        cache_miss_count    = v.misses;
        decode_count        = v.decode;
    endtask

    // The simultaneous read must return the pre-capture total.
    task automatic capture(input vec_t v);
        drive(v);
        measurement_done = 1'b1;
        csr_rd_en        = 1'b1;
        csr_rd_addr      = 3'd0;
        exp_q.push_back(prev_total);
        tick();
        measurement_done = 1'b0;
        csr_rd_en        = 1'b0;
        prev_total       = v.total;
        chk("busy_after_capture", 32'(busy), 32'd1);
        chk("snap_valid_after_capture", 32'(snap_valid), 32'd0);
    endtask

    task automatic wait_publish(input int exp_cyc);
        int n = 0;
        while (!snap_valid && n < 200) begin
            tick();
            n++;
        end
        chk("publish_cycles", 32'(n), 32'(exp_cyc));
        chk("busy_after_publish", 32'(busy), 32'd0);
        chk("irq_after_publish", 32'(irq), 32'd1);
    endtask

    initial begin
        //          total         active        idle  hits  misses decode util
        vecs[0] = '{32'd100,      32'd100,      32'd0, 32'd1, 32'd2,  32'd3,  10'd1000};
        vecs[1] = '{32'd50,       32'd26,       32'd24, 32'd4, 32'd5, 32'd6,  10'd520};
        vecs[2] = '{32'd10,       32'd0,        32'd10, 32'd7, 32'd8, 32'd9,  10'd0};
        vecs[3] = '{32'd0,        32'd0,        32'd0, 32'd11, 32'd12, 32'd13, 10'd0};
        vecs[4] = '{32'd3,        32'd5,        32'd0, 32'd150, 32'd10, 32'd50, 10'd1000};
        vecs[5] = '{32'd7,        32'd3,        32'd4, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 10'd428};
        vecs[6] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 32'd0, 32'd0, 10'd500};

        rst = 1'b1;
        measurement_done = 1'b0;
        csr_rd_en = 1'b0;
        csr_rd_addr = 3'd0;
        irq_clr = 1'b0;
        drive(vecs[0]);
        tick();
        tick();
        chk("rst_util", 32'(util_permille), 32'd0);
        chk("rst_snap_valid", 32'(snap_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_rd_valid", 32'(csr_rd_valid), 32'd0);
        chk("rst_rd_data", csr_rd_data, 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            capture(vecs[i]);
            wait_publish(vecs[i].total == 32'd0 ? 2 : NW + 1);
            exp_seq++;
            chk("util", 32'(util_permille), 32'(vecs[i].util));
            rd(3'd0, vecs[i].total);
            rd(3'd1, vecs[i].active);
            rd(3'd2, vecs[i].idle);
            rd(3'd3, vecs[i].hits);
            rd(3'd4, vecs[i].misses);
            rd(3'd5, vecs[i].decode);
            rd(3'd6, 32'(vecs[i].util));
            rd(3'd7, st(1'b0, exp_seq, 1'b0, 1'b1));
            irq_clr = 1'b1;
            tick();
            irq_clr = 1'b0;
            chk("irq_cleared", 32'(irq), 32'd0);
        end

        // Overrun: second pulse mid-DIV is ignored, irq_clr on publish edge loses to set.
        va = '{32'd1000, 32'd250, 32'd750, 32'd21, 32'd22, 32'd23, 10'd250};
        vb = '{32'd77, 32'd77, 32'd0, 32'd31, 32'd32, 32'd33, 10'd1000};
        capture(va);
        repeat (5) tick();
        drive(vb);
        measurement_done = 1'b1;
        tick();
        measurement_done = 1'b0;
        rd(3'd7, st(1'b1, exp_seq, 1'b1, 1'b0));
        rd(3'd0, va.total);
        repeat (NW - 8) tick();
        chk("no_early_publish", 32'(snap_valid), 32'd0);
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        exp_seq++;
        chk("ovr_publish", 32'(snap_valid), 32'd1);
        chk("irq_set_wins", 32'(irq), 32'd1);
        chk("ovr_util", 32'(util_permille), 32'(va.util));
        rd(3'd7, st(1'b0, exp_seq, 1'b0, 1'b1));
        repeat (50) tick();
        rd(3'd7, st(1'b0, exp_seq, 1'b0, 1'b1));
        rd(3'd1, va.active);
        rd(3'd3, va.hits);

        // Reset in the middle of a division.
        capture(vecs[1]);
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_seq = 16'd0;
        prev_total = 32'd0;
        chk("midrst_util", 32'(util_permille), 32'd0);
        chk("midrst_snap_valid", 32'(snap_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_irq", 32'(irq), 32'd0);
        chk("midrst_rd_valid", 32'(csr_rd_valid), 32'd0);
        chk("midrst_rd_data", csr_rd_data, 32'd0);
        tick();
        chk("midrst_stays_idle", 32'(busy), 32'd0);
        rd(3'd7, 32'd0);
        rd(3'd0, 32'd0);
        capture(vecs[5]);
        wait_publish(NW + 1);
        exp_seq++;
        chk("after_rst_util", 32'(util_permille), 32'(vecs[5].util));
        rd(3'd7, st(1'b0, exp_seq, 1'b0, 1'b1));
        rd(3'd2, vecs[5].idle);

        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule
